// File: rtl/mnist_pkg.sv
// Shared constants and state encoding for the MNIST frame scheduler.
package mnist_pkg;

    localparam int PIX_W  = 8;
    localparam int N_PIX  = 784;
    localparam int PRED_W = 4;
    localparam int CONF_W = 8;

    localparam logic [PRED_W-1:0] TIMEOUT_PRED = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the source not granted last wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       last_o
);

    always_comb begin
        gnt_o  = 2'b00;
        last_o = last_i;
        if (en_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
            if (|gnt_o) begin
                last_o = gnt_o[1];
            end
        end
    end

endmodule

// File: rtl/mnist_frame_sched.sv
// Shares one MNIST classifier between two pixel sources, one frame at a time,
// returning each result tagged with its source and guarded by a watchdog.
module mnist_frame_sched #(
    parameter int N_PIX   = mnist_pkg::N_PIX,
    parameter int PIX_W   = mnist_pkg::PIX_W,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    input  logic [PIX_W-1:0] s0_data,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [PIX_W-1:0] s1_data,
    input  logic             s1_valid,
    output logic             s1_ready,
    output logic [PIX_W-1:0] nn_data,
    output logic             nn_valid,
    input  logic [3:0]       nn_pred,
    input  logic [7:0]       nn_conf,
    input  logic             nn_done,
    output logic             res_valid,
    output logic             res_id,
    output logic [3:0]       res_pred,
    output logic [7:0]       res_conf,
    output logic             res_timeout,
    output logic             busy
);

    import mnist_pkg::*;

    localparam int CW = $clog2(N_PIX);
    localparam int WW = $clog2(TIMEOUT);

    sched_state_e      state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WW-1:0]     wd_q, wd_d;
    logic [PIX_W-1:0]  nn_data_q, nn_data_d;
    logic              nn_valid_q, nn_valid_d;
    logic              res_id_q, res_id_d;
    logic [PRED_W-1:0] res_pred_q, res_pred_d;
    logic [CONF_W-1:0] res_conf_q, res_conf_d;
    logic              res_to_q, res_to_d;

    logic [1:0]        arb_gnt;
    logic              arb_last;
    logic              hs;
    logic [PIX_W-1:0]  pix;

    rr_arb2 u_arb (
        .req_i  (req),
        .last_i (last_q),
        .en_i   (state_q == IDLE),
        .gnt_o  (arb_gnt),
        .last_o (arb_last)
    );

    assign s0_ready = (state_q == STREAM) & gnt_q[0];
    assign s1_ready = (state_q == STREAM) & gnt_q[1];
    assign hs       = (s0_valid & s0_ready) | (s1_valid & s1_ready);
    assign pix      = gnt_q[1] ? s1_data : s0_data;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        wd_d       = wd_q;
        nn_data_d  = nn_data_q;
        nn_valid_d = 1'b0;
        res_id_d   = res_id_q;
        res_pred_d = res_pred_q;
        res_conf_d = res_conf_q;
        res_to_d   = res_to_q;
        unique case (state_q)
            IDLE: begin
                // Pointer moves at grant; every grant ends in RESULT or reset.
                if (|arb_gnt) begin
                    gnt_d   = arb_gnt;
                    last_d  = arb_last;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (hs) begin
                    nn_data_d  = pix;
                    nn_valid_d = 1'b1;
                    if (cnt_q == CW'(N_PIX - 1)) begin
                        cnt_d   = '0;
                        wd_d    = '0;
                        state_d = WAIT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            WAIT: begin
                wd_d = wd_q + WW'(1);
                if (nn_done) begin
                    res_pred_d = nn_pred;
                    res_conf_d = nn_conf;
                    res_to_d   = 1'b0;
                    res_id_d   = gnt_q[1];
                    wd_d       = '0;
                    state_d    = RESULT;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    res_pred_d = TIMEOUT_PRED;
                    res_conf_d = '0;
                    res_to_d   = 1'b1;
                    res_id_d   = gnt_q[1];
                    wd_d       = '0;
                    state_d    = RESULT;
                end
            end
            RESULT: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            wd_q       <= '0;
            nn_data_q  <= '0;
            nn_valid_q <= 1'b0;
            res_id_q   <= 1'b0;
            res_pred_q <= '0;
            res_conf_q <= '0;
            res_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            nn_data_q  <= nn_data_d;
            nn_valid_q <= nn_valid_d;
            res_id_q   <= res_id_d;
            res_pred_q <= res_pred_d;
            res_conf_q <= res_conf_d;
            res_to_q   <= res_to_d;
        end
    end

    assign gnt         = gnt_q;
    assign nn_data     = nn_data_q;
    assign nn_valid    = nn_valid_q;
    assign res_valid   = (state_q == RESULT);
    assign res_id      = res_id_q;
    assign res_pred    = res_pred_q;
    assign res_conf    = res_conf_q;
    assign res_timeout = res_to_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mnist_frame_sched.sv
// Randomized frame-level bench for mnist_frame_sched against a
// transaction model of arbitration order, pixel stream and result timing.
module tb_mnist_frame_sched;

    localparam int NP = 784;
    localparam int PW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = '0;
    logic [1:0]    gnt;
    logic [PW-1:0] s0_data = '0;
    logic          s0_valid = 1'b0;
    logic          s0_ready;
    logic [PW-1:0] s1_data = '0;
    logic          s1_valid = 1'b0;
    logic          s1_ready;
    logic [PW-1:0] nn_data;
    logic          nn_valid;
    logic [3:0]    nn_pred = '0;
    logic [7:0]    nn_conf = '0;
    logic          nn_done = 1'b0;
    logic          res_valid;
    logic          res_id;
    logic [3:0]    res_pred;
    logic [7:0]    res_conf;
    logic          res_timeout;
    logic          busy;

    always #5 clk = ~clk;

    mnist_frame_sched #(
        .N_PIX   (NP),
        .PIX_W   (PW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .gnt         (gnt),
        .s0_data     (s0_data),
        .s0_valid    (s0_valid),
        .s0_ready    (s0_ready),
        .s1_data     (s1_data),
        .s1_valid    (s1_valid),
        .s1_ready    (s1_ready),
        .nn_data     (nn_data),
        .nn_valid    (nn_valid),
        .nn_pred     (nn_pred),
        .nn_conf     (nn_conf),
        .nn_done     (nn_done),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_pred    (res_pred),
        .res_conf    (res_conf),
        .res_timeout (res_timeout),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;
    logic m_last;
    bit in_result;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({gnt, s0_ready, s1_ready, nn_valid, nn_data, res_valid,
                    res_id, res_pred, res_conf, res_timeout, busy});
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        nn_done = 1'b0;
        #1;
        chk("rst_out", out_vec(), 0);
        repeat (2) @(negedge clk);
        chk("rst_hold", out_vec(), 0);
        rst_n = 1'b1;
        m_last = 1'b1;
        in_result = 1'b0;
        @(negedge clk);
        chk("post_rst", out_vec(), 0);
    endtask

    task automatic go_idle();
        req = '0;
        @(negedge clk);
        if (in_result) chk("res_pulse", res_valid, 0);
        @(negedge clk);
        chk("idle", {gnt, busy}, 0);
        in_result = 1'b0;
    endtask

    task automatic run_frame(input logic [1:0] rp, input int gap_pct,
                             input int d, input bit noise, input int rst_at,
                             input logic [3:0] fp, input logic [7:0] fc);
        logic [PW-1:0] pix [NP];
        int win, waited, hs_cnt, beats, bad, viol, cyc, lat, exp_lat;
        bit hs_prev, v, hs, exp_to;
        for (int k = 0; k < NP; k++) pix[k] = PW'($urandom);
        win = (rp == 2'b11) ? (m_last ? 0 : 1) : (rp[1] ? 1 : 0);
        m_last = win[0];
        req = rp;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
            if (waited == 1 && in_result) chk("res_pulse", res_valid, 0);
        end while (gnt == 2'b00 && waited < 6);
        chk("gnt", gnt, 1 << win);
        chk("gnt_lat", waited, in_result ? 2 : 1);
        in_result = 1'b0;

        hs_cnt = 0; beats = 0; bad = 0; viol = 0; cyc = 0; hs_prev = 0;
        forever begin
            if (nn_valid !== hs_prev) bad++;
            if (nn_valid === 1'b1) begin
                if (beats >= NP || nn_data !== pix[beats]) bad++;
                beats++;
            end
            if (hs_cnt == NP) break;
            if (hs_cnt == rst_at) begin
                do_reset();
                return;
            end
            if (cyc++ > NP * 8) begin
                chk("stream_tmo", hs_cnt, NP);
                break;
            end
            if (win == 0 ? (s0_ready !== 1'b1 || s1_ready !== 1'b0)
                         : (s1_ready !== 1'b1 || s0_ready !== 1'b0)) viol++;
            v = ($urandom_range(99) >= gap_pct);
            if (win == 0) begin
                s0_valid = v; s0_data = pix[hs_cnt];
                s1_valid = 1'($urandom); s1_data = PW'($urandom);
                hs = v && s0_ready;
            end else begin
                s1_valid = v; s1_data = pix[hs_cnt];
                s0_valid = 1'($urandom); s0_data = PW'($urandom);
                hs = v && s1_ready;
            end
            if (hs) hs_cnt++;
            hs_prev = hs;
            nn_done = noise ? ($urandom_range(7) == 0) : 1'b0;
            nn_pred = 4'($urandom);
            nn_conf = 8'($urandom);
            @(negedge clk);
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        chk("beats", beats, NP);
        chk("beat_err", bad, 0);
        chk("ready", viol, 0);

        exp_lat = (d < TO) ? d + 1 : TO;
        exp_to = (d >= TO);
        lat = -1;
        for (int c = 0; c <= TO + 4; c++) begin
            if (res_valid === 1'b1) begin
                lat = c;
                break;
            end
            nn_done = (c == d);
            nn_pred = (c == d) ? fp : 4'($urandom);
            nn_conf = (c == d) ? fc : 8'($urandom);
            @(negedge clk);
        end
        nn_done = 1'b0;
        chk("res_lat", lat, exp_lat);
        chk("res_id", res_id, win);
        chk("res_pred", res_pred, exp_to ? 4'hF : fp);
        chk("res_conf", res_conf, exp_to ? 8'd0 : fc);
        chk("res_to", res_timeout, exp_to);
        chk("gnt_hold", {gnt, busy}, {2'(1 << win), 1'b1});
        in_result = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got %0d exp %0d", checks, 0);
        $fatal(1, "bench timeout");
    end

    initial begin
        m_last = 1'b1;
        in_result = 1'b0;
        @(negedge clk);
        do_reset();
        run_frame(2'b01, 0, 10, 0, -1, 4'd7, 8'd200);
        go_idle();
        do_reset();
        repeat (4) run_frame(2'b11, 30, $urandom_range(TO - 1), 1, -1,
                             4'($urandom), 8'($urandom));
        go_idle();
        run_frame(2'b10, 50, 5, 0, -1, 4'($urandom), 8'($urandom));
        go_idle();
        run_frame(2'b01, 20, 1000, 1, -1, 4'd3, 8'd99);
        run_frame(2'b10, 0, 3, 0, -1, 4'd9, 8'd17);
        run_frame(2'b01, 10, TO - 1, 1, -1, 4'd5, 8'd128);
        go_idle();
        run_frame(2'b01, 10, 4, 0, 300, 4'd1, 8'd2);
        run_frame(2'b01, 25, 6, 0, -1, 4'd2, 8'd77);
        repeat (4) run_frame(2'($urandom_range(3, 1)), $urandom_range(60),
                             $urandom_range(20), 1'($urandom), -1,
                             4'($urandom), 8'($urandom));
        go_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mnist_frame_sched.md
# mnist_frame_sched

Shares the single MNIST classifier (`top`: byte pixel stream in, 4-bit prediction and 8-bit confidence out) between two frame sources. Round-robin arbitration grants one source at a time and forwards exactly N_PIX pixels from it to the classifier. The block then waits for the classifier result, with a watchdog, and returns the result tagged with the requester id. It sits between the pixel sources (camera/DMA/test feeders) and the classifier.

## Interface
- N_PIX, 784, pixels per frame
- PIX_W, 8, pixel width
- TIMEOUT, 4096, max cycles in WAIT before a timeout result
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset; the same net resets the classifier
- req  in  2  per-source frame request, level
- gnt  out  2  one-hot grant, held for the whole frame through RESULT
- s0_data, s1_data  in  PIX_W  source pixel
- s0_valid, s1_valid  in  1  source pixel valid
- s0_ready, s1_ready  out  1  pixel accepted when valid&ready
- nn_data  out  PIX_W  to classifier data_in
- nn_valid  out  1  to classifier valid_in
- nn_pred  in  4  classifier prediction
- nn_conf  in  8  classifier confidence
- nn_done  in  1  classifier valid_out
- res_valid  out  1  one-cycle result strobe
- res_id  out  1  source index of the result
- res_pred  out  4  prediction
- res_conf  out  8  confidence
- res_timeout  out  1  result produced by the watchdog
- busy  out  1  state != IDLE

## Operation
- States: IDLE, STREAM, WAIT, RESULT.
- IDLE: if req != 0, pick the winner → gnt, go to STREAM. If both request, the winner is the source not granted last. The last-grant pointer resets to 1, so source 0 wins the first tie.
- STREAM: sK_ready = 1 for the granted K only; the other ready is 0. Each handshake registers sK_data → nn_data with nn_valid = 1. No handshake → nn_valid = 0 (gaps allowed). Pixel counter ($clog2(N_PIX) bits) increments per handshake. Handshake at count N_PIX-1 → WAIT, counter cleared.
- WAIT: the watchdog counter ($clog2(TIMEOUT) bits) increments each cycle.
  - nn_done = 1 → capture nn_pred/nn_conf, go to RESULT.
  - Watchdog at TIMEOUT-1 without nn_done → res_pred = 4'hF, res_conf = 0, res_timeout = 1, go to RESULT.
  - nn_done and the timeout on the same cycle: nn_done wins, res_timeout = 0.
- RESULT: res_valid = 1 for exactly one cycle; res_id = granted index. Update the last-grant pointer; gnt → 0; go to IDLE.
- nn_done outside WAIT is ignored.
- req dropping mid-frame is ignored: the frame completes N_PIX beats. A source must not withdraw once granted.
- res_* hold their value until the next result. Only res_valid qualifies them.
- Reset (any time, including mid-frame):
  - state IDLE; gnt, sK_ready, nn_valid, res_valid, res_timeout, busy = 0.
  - nn_data, res_pred, res_conf, res_id = 0; counters = 0.
  - Partial frames are discarded.

## Timing
- Grant: req seen in IDLE at edge t → gnt and ready high after edge t.
- Pixel latency: handshake at edge t → nn_data/nn_valid valid in the cycle after t. Registered, no combinational path from sK_data.
- Throughput: 1 pixel/cycle. Minimum frame time is N_PIX STREAM cycles plus 1 IDLE, ≥1 WAIT and 1 RESULT cycle.
- nn_done sampled at edge t in WAIT → res_valid high in the cycle after t.
- Timeout: res_valid rises TIMEOUT cycles after entering WAIT.
- Back-to-back: IDLE re-arbitrates in the cycle after RESULT.
- All outputs are registered or decoded from registered state/gnt only.

## Structure
- Shared package `mnist_pkg`: PIX_W, N_PIX, PRED_W = 4, CONF_W = 8, TIMEOUT_PRED = 4'hF, and the state encoding constants (IDLE, STREAM, WAIT, RESULT).
- Sub-module `rr_arb2`: 2-way round-robin arbiter.
  - Inputs: req[1:0], last, en.
  - Outputs: one-hot gnt, updated pointer.
  - Reused by the later multi-source feeder.
- FSM, counters, pixel register and result register live in the top of this block.

## Test plan
- Only s0 requests, streams 784 pixels with no gaps; classifier stub asserts nn_done 10 cycles later with pred 7, conf 200 → nn_valid high for exactly 784 cycles; one res_valid, res_id = 0, res_pred = 7, res_conf = 200, res_timeout = 0.
- Both request from reset → s0 served first, then s1 without idle gap beyond 1 cycle. Both request again → s1 is not starved: order is 0, 1, 0, 1.
- s1 inserts random valid gaps (50%) → exactly 784 nn_valid beats, data order preserved, pixel k on nn_data one cycle after its handshake.
- Stub never asserts nn_done, TIMEOUT = 16 → res_valid 16 cycles after entering WAIT with res_pred = 15, res_conf = 0, res_timeout = 1; the next request is granted normally.
- rst_n pulsed low at pixel 300, then s0 re-requests → all outputs 0 during reset. The new frame produces exactly 784 beats and a single result.
- nn_done pulsed during STREAM and on the same cycle as the timeout → the first is ignored; the second yields res_timeout = 0 with the captured values.
